// File: rtl/seq_detector_p.sv
// seq_detector_p: serial pattern detector (clk, reset, en/in bit stream, pat_we/pat_in/mask_in load, cnt_clr) -> out pulse, match_cnt, armed
module seq_detector_p #(
    parameter int LEN = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b11011,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    input  logic             pat_we,
    input  logic [LEN-1:0]   pat_in,
    input  logic [LEN-1:0]   mask_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);
    logic [LEN-1:0] hist, pat, msk, cand;
    logic [FW-1:0] fill;
    logic hit;
    always_comb begin
        cand = {hist[LEN-2:0], in};
        hit = en && !pat_we && fill == FULL && ((cand ^ pat) & msk) == '0;
        armed = fill == FULL;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= 1'b0;
            match_cnt <= '0;
            hist <= '0;
            fill <= '0;
            pat <= PATTERN;
            msk <= '1;
        end else begin
            out <= hit;
            if (pat_we) begin
                pat <= pat_in;
                msk <= mask_in;
                fill <= '0;
            end else if (en) begin
                hist <= cand;
                fill <= hit ? (OVERLAP ? FULL : '0) : (fill == FULL ? FULL : fill + FW'(1));
            end
            match_cnt <= cnt_clr ? '0 : (hit && match_cnt != '1) ? match_cnt + CNT_W'(1) : match_cnt;
        end
    end
endmodule

// File: doc/seq_detector_p.md
SEQ_DETECTOR_P -- requirements
Module: seq_detector_p

Interface
REQ-001 Parameter LEN, default 5: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 5'b11011: reset value of the pattern register; the MSB is compared against the oldest bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of match counter.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 en  input  1  bit-valid strobe; in is consumed only when en=1.
REQ-008 in  input  1  serial data bit.
REQ-009 pat_we  input  1  runtime pattern/mask load strobe.
REQ-010 pat_in  input  LEN  new pattern value, loaded when pat_we=1.
REQ-011 mask_in  input  LEN  new compare mask; bit=0 means don't-care; loaded with pat_in.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-013 out  output  1  registered match pulse.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 armed  output  1  high when fill count has reached LEN-1, i.e. the next accepted bit can complete a match.

Function
REQ-016 The block SHALL hold a LEN-bit history shift register hist, a fill counter fill (0..LEN-1, saturating), a pattern register pat and a mask register msk.
REQ-017 On an accepted bit (en=1, pat_we=0), the block SHALL form cand = {hist[LEN-2:0], in}, write cand to hist, and evaluate the match condition ((cand ^ pat) & msk) == 0 AND fill == LEN-1.
REQ-018 The out signal SHALL be registered: a match on the edge that samples the final bit drives out=1 for exactly the following cycle; no-match, en=0 or pat_we=1 drives out=0.
REQ-019 With OVERLAP=1, fill SHALL stay at LEN-1 after a match, so a suffix of a match can begin the next match.
REQ-020 With OVERLAP=0, fill SHALL reset to 0 on a match, so the next match requires LEN fresh accepted bits.
REQ-021 On a non-matching accepted bit, fill SHALL increment, saturating at LEN-1.
REQ-022 When en=0, hist, fill and match_cnt SHALL hold, and out SHALL be 0 the next cycle; gaps do not break a sequence.
REQ-023 When pat_we=1, the block SHALL load pat<=pat_in and msk<=mask_in, clear fill and out, and discard any bit presented with en=1 in the same cycle.
REQ-024 A match SHALL increment match_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 When cnt_clr=1, match_cnt SHALL be set to 0; if a match occurs in the same cycle, the clear wins and the match is not counted, but out still pulses.
REQ-026 armed SHALL equal (fill == LEN-1) combinationally from registers.

Reset
REQ-027 When reset=1 at posedge clk, the block SHALL set out=0, match_cnt=0, hist=0, fill=0, pat=PATTERN and msk=all ones; reset overrides en, pat_we and cnt_clr.
REQ-028 Reset asserted mid-sequence SHALL discard all partial history; no match is possible until LEN bits are accepted after reset deasserts.

Verification
REQ-029 Defaults, en=1, in=1,1,0,1,1,0,1,1 -> out=1 in the cycle after bit 5 and after bit 8; match_cnt=2.
REQ-030 Same stream with OVERLAP=0 -> out=1 only after bit 5; match_cnt=1.
REQ-031 in=1,1,0 then en=0 for 3 cycles then in=1,1 -> out=1 once, after the last bit; out=0 during the gap.
REQ-032 pat_we with pat_in=5'b10101 and mask_in=5'b11011, then in=1,0,1,0,1 and 1,0,0,0,1 -> one match each; a bit presented with pat_we is ignored.
REQ-033 CNT_W=2, 5 consecutive matches (OVERLAP=1, pattern 11111, stream of 9 ones) -> match_cnt saturates at 3; cnt_clr coincident with a match -> match_cnt=0 and out=1.
REQ-034 reset pulsed after in=1,1,0,1 -> a following in=1 gives no match; armed=0 until 4 bits are accepted after reset.
